// File: rtl/mips_fetch_queue.sv
// rtl/mips_fetch_queue.sv - MIPS fetch stage: imem request/response handshake feeding an in-order prefetch queue
// Optional FETCH_BYPASS_EN forwards an arriving response straight to decode while the queue is empty.
module mips_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pcplus4,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  // Stale responses can pile up over several back-to-back redirects, so drop is kept wide.
  localparam int DW = 16;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DW-1:0]   drop_q, drop_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   tag_wr_q, tag_wr_d;
  logic [PW-1:0]   tag_rd_q, tag_rd_d;

  logic [31:0]     q_instr_q [DEPTH];
  logic [XLEN-1:0] q_pc4_q   [DEPTH];
  logic [XLEN-1:0] tag_q     [DEPTH];

  logic accept;
  logic rsp_own;
  logic stale;
  logic keep;
  logic byp;
  logic head_valid;
  logic pop;
  logic pop_head;
  logic push;
  logic unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  assign imem_req  = !reset && !redirect &&
                     (({1'b0, outst_q} + {1'b0, count_q}) < DEPTH_W);
  assign imem_addr = fpc_q;
  assign accept    = imem_req && imem_ready;

  // A response with drop==0 belongs to the oldest live tag; otherwise it is stale.
  assign rsp_own = imem_rvalid && (drop_q == '0);
  assign stale   = imem_rvalid && (drop_q != '0);
  assign keep    = rsp_own && !redirect;

`ifdef FETCH_BYPASS_EN
  assign byp = keep && (count_q == '0);
`else
  assign byp = 1'b0;
`endif

  assign head_valid  = (count_q != '0);
  assign instr_valid = head_valid || byp;
  assign pop         = instr_valid && instr_ready && !redirect;
  assign pop_head    = pop && head_valid;
  assign push        = keep && !(byp && pop);

  always_comb begin
    instr   = '0;
    pcplus4 = '0;
    if (head_valid) begin
      instr   = q_instr_q[rd_ptr_q];
      pcplus4 = q_pc4_q[rd_ptr_q];
    end else if (byp) begin
      instr   = imem_rdata;
      pcplus4 = tag_q[tag_rd_q];
    end
  end

  always_comb begin
    fpc_d    = fpc_q;
    outst_d  = outst_q;
    count_d  = count_q;
    drop_d   = drop_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    tag_wr_d = tag_wr_q;
    tag_rd_d = tag_rd_q;
    if (redirect) begin
      // Everything still in flight becomes stale; a response arriving now is discarded too.
      fpc_d    = {redirect_pc[XLEN-1:2], 2'b00};
      drop_d   = drop_q + DW'(outst_q) - DW'(imem_rvalid);
      outst_d  = '0;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      tag_wr_d = '0;
      tag_rd_d = '0;
    end else begin
      if (accept) begin
        fpc_d    = fpc_q + XLEN'(4);
        tag_wr_d = tag_wr_q + PW'(1);
      end
      if (stale) begin
        drop_d = drop_q - DW'(1);
      end
      if (rsp_own) begin
        tag_rd_d = tag_rd_q + PW'(1);
      end
      outst_d = outst_q + CW'(accept) - CW'(rsp_own);
      count_d = count_q + CW'(push) - CW'(pop_head);
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop_head) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_q    <= RESET_PC;
      outst_q  <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
    end else begin
      fpc_q    <= fpc_d;
      outst_q  <= outst_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
    end
  end

  // Storage needs no reset: contents are only visible behind count/outstanding.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_q[tag_wr_q] <= fpc_q + XLEN'(4);
    end
    if (push) begin
      q_instr_q[wr_ptr_q] <= imem_rdata;
      q_pc4_q[wr_ptr_q]   <= tag_q[tag_rd_q];
    end
  end

endmodule

// File: tb/tb_mips_fetch_queue.sv
// tb/tb_mips_fetch_queue.sv - scoreboard bench for mips_fetch_queue with randomized memory/decode behaviour
module tb_mips_fetch_queue;

  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam int FIRST_VALID = 1;
`else
  localparam int FIRST_VALID = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pcplus4;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  mips_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .pcplus4(pcplus4),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] model_pc;
  int          cyc;
  int          lat = 1;
  bit          rand_lat = 0;
  int          acc_cnt;
  int          pops_cnt;
  int          first_valid_cyc;
  bit          first_pop_armed;
  logic [63:0] first_pop;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: whatever decode sees must be the oldest un-consumed fetch in program order.
  always @(negedge clk) begin
    if (!reset) begin
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_instr", {32'h0, instr}, 64'hdead);
        end else begin
          chk("instr", {32'h0, instr}, {32'h0, exp_q[0][31:0]});
          chk("pcplus4", {32'h0, pcplus4}, {32'h0, exp_q[0][63:32]});
          if (instr_ready && !redirect) begin
            if (first_pop_armed) begin
              first_pop = exp_q[0];
              first_pop_armed = 0;
            end
            void'(exp_q.pop_front());
            pops_cnt++;
          end
        end
      end else begin
        chk("idle_outputs_zero", {instr, pcplus4}, 64'h0);
      end
    end
  end

  // One clock cycle: entered and left at posedge+1.
  task automatic step(input bit mrdy, input bit drdy, input bit redir, input logic [31:0] rpc);
    imem_ready  = mrdy;
    instr_ready = drdy;
    redirect    = redir;
    redirect_pc = rpc;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend_q[0].addr;
      void'(pend_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    chk("imem_req", {63'h0, imem_req}, {63'h0, (!redir && exp_q.size() < DEPTH)});
    if (imem_req) chk("imem_addr", {32'h0, imem_addr}, {32'h0, model_pc});
    if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    @(negedge clk);
    #1;
    if (imem_req && imem_ready) begin
      pend_q.push_back('{addr: imem_addr,
                         due: cyc + (rand_lat ? int'($urandom_range(1, 4)) : lat)});
      exp_q.push_back({model_pc + 32'd4, model_pc});
      model_pc += 32'd4;
      acc_cnt++;
    end
    if (redir) begin
      exp_q.delete();
      model_pc = {rpc[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    pend_q.delete();
    exp_q.delete();
    model_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    acc_cnt = 0;
    pops_cnt = 0;
    first_valid_cyc = -1;
    first_pop_armed = 0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk("rst_imem_req", {63'h0, imem_req}, 64'h0);
    chk("rst_imem_addr", {32'h0, imem_addr}, 64'h0);
    chk("rst_instr_valid", {63'h0, instr_valid}, 64'h0);
    chk("rst_instr", {32'h0, instr}, 64'h0);
    chk("rst_pcplus4", {32'h0, pcplus4}, 64'h0);

    // Startup with single-cycle memory and decode always ready.
    do_reset();
    lat = 1;
    repeat (12) step(1, 1, 0, 0);
    chk("first_valid_cycle", 64'(first_valid_cyc), 64'(FIRST_VALID));
    chk("startup_throughput", 64'(pops_cnt), 64'(12 - FIRST_VALID));

    // Decode stalled: queue fills to DEPTH, then requests stop.
    do_reset();
    repeat (10) step(1, 0, 0, 0);
    chk("stall_accepts", 64'(acc_cnt), 64'(DEPTH));
    chk("full_req_low", {63'h0, imem_req}, 64'h0);
    pops_cnt = 0;
    repeat (12) step(1, 1, 0, 0);
    chk("drain_pops", {63'h0, (pops_cnt >= DEPTH)}, 64'h1);

    // Latency 3 with toggling memory ready.
    do_reset();
    lat = 3;
    for (int i = 0; i < 40; i++) step(i[0] == 1'b0, $urandom_range(0, 3) != 0, 0, 0);

    // Redirect with two requests in flight.
    do_reset();
    lat = 3;
    repeat (2) step(1, 1, 0, 0);
    step(1, 1, 1, 32'h1003);
    first_pop_armed = 1;
    repeat (12) step(1, 1, 0, 0);
    chk("redirect_first_instr", first_pop, {32'h1004, 32'h1000});

    // Redirect coinciding with a response and a decode pop.
    do_reset();
    lat = 1;
    repeat (6) step(1, 1, 0, 0);
    step(1, 1, 1, 32'h2000);
    chk("flush_empty", {63'h0, instr_valid}, 64'h0);
    first_pop_armed = 1;
    repeat (8) step(1, 1, 0, 0);
    chk("redirect2_first_instr", first_pop, {32'h2004, 32'h2000});

    // Asynchronous reset with three queued instructions.
    do_reset();
    lat = 1;
    for (int i = 0; i < 10 && acc_cnt < 3; i++) step(1, 0, 0, 0);
    chk("accepts_before_reset", 64'(acc_cnt), 64'd3);
    repeat (3) step(0, 0, 0, 0);
    chk("valid_before_reset", {63'h0, instr_valid}, 64'h1);
    reset = 1'b1;
    imem_rvalid = 1'b0;
    #1;
    chk("async_imem_req", {63'h0, imem_req}, 64'h0);
    chk("async_imem_addr", {32'h0, imem_addr}, 64'h0);
    chk("async_instr_valid", {63'h0, instr_valid}, 64'h0);
    chk("async_outputs", {instr, pcplus4}, 64'h0);
    do_reset();
    repeat (10) step(1, 1, 0, 0);

    // Random traffic, starting with a redirect near the top of the address space.
    do_reset();
    rand_lat = 1;
    step(1, 1, 1, 32'hFFFF_FFF9);
    repeat (8) step(1, 1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 39) == 0, $urandom);
    end
    rand_lat = 0;
    lat = 1;
    repeat (20) step(1, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
